// File: rtl/perf_counter_unit.sv
// Performance monitor: counts cycles, retired instructions, resolved and mispredicted
// branches, and freezes all counts once the fetch PC reaches HALT_PC.
module perf_counter_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     CNT_W    = 32,
    parameter logic [XLEN-1:0] HALT_PC  = XLEN'(32'h44),
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_valid,
    input  logic             retire,
    input  logic             branch_resolved,
    input  logic             branch_mispredict,
    input  logic             clear,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] branches,
    output logic [CNT_W-1:0] mispredicts,
    output logic [3:0]       ovf,
    output logic             done,
    output logic             halt_pulse
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cycles_r;
    logic [CNT_W-1:0] instret_r;
    logic [CNT_W-1:0] branches_r;
    logic [CNT_W-1:0] mispredicts_r;
    logic [3:0]       ovf_r;
    logic             done_r;
    logic             halt_pulse_r;

    // Next counter values; the MSB carries the overflow event of that increment.
    logic [CNT_W:0]   cycles_nx_s;
    logic [CNT_W:0]   instret_nx_s;
    logic [CNT_W:0]   branches_nx_s;
    logic [CNT_W:0]   mispredicts_nx_s;
    logic             halt_match_s;

    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] value, input logic en);
        logic [CNT_W:0] result;
        if (!en) begin
            result = {1'b0, value};
        end else if (value == {CNT_W{1'b1}}) begin
            result = {1'b1, (SATURATE ? value : {CNT_W{1'b0}})};
        end else begin
            result = {1'b0, value + CNT_W'(1)};
        end
        return result;
    endfunction

    // Candidate counter updates and halt-address match for the current cycle.
    always_comb begin
        cycles_nx_s      = bump(cycles_r, 1'b1);
        instret_nx_s     = bump(instret_r, retire);
        branches_nx_s    = bump(branches_r, branch_resolved);
        mispredicts_nx_s = bump(mispredicts_r, branch_resolved & branch_mispredict);
        halt_match_s     = pc_valid && (pc == HALT_PC);
    end

    // Measurement-window FSM with registered counters and flags; clear beats counting and halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= RUN;
            cycles_r      <= {CNT_W{1'b0}};
            instret_r     <= {CNT_W{1'b0}};
            branches_r    <= {CNT_W{1'b0}};
            mispredicts_r <= {CNT_W{1'b0}};
            ovf_r         <= 4'b0000;
            done_r        <= 1'b0;
            halt_pulse_r  <= 1'b0;
        end else if (clear) begin
            state_r       <= RUN;
            cycles_r      <= {CNT_W{1'b0}};
            instret_r     <= {CNT_W{1'b0}};
            branches_r    <= {CNT_W{1'b0}};
            mispredicts_r <= {CNT_W{1'b0}};
            ovf_r         <= 4'b0000;
            done_r        <= 1'b0;
            halt_pulse_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    cycles_r      <= cycles_nx_s[CNT_W-1:0];
                    instret_r     <= instret_nx_s[CNT_W-1:0];
                    branches_r    <= branches_nx_s[CNT_W-1:0];
                    mispredicts_r <= mispredicts_nx_s[CNT_W-1:0];
                    ovf_r         <= ovf_r | {mispredicts_nx_s[CNT_W], branches_nx_s[CNT_W],
                                              instret_nx_s[CNT_W], cycles_nx_s[CNT_W]};
                    if (halt_match_s) begin
                        state_r      <= HALTED;
                        done_r       <= 1'b1;
                        halt_pulse_r <= 1'b1;
                    end else begin
                        halt_pulse_r <= 1'b0;
                    end
                end
                HALTED: begin
                    halt_pulse_r <= 1'b0;
                end
                default: begin
                    state_r      <= RUN;
                    halt_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign cycles      = cycles_r;
    assign instret     = instret_r;
    assign branches    = branches_r;
    assign mispredicts = mispredicts_r;
    assign ovf         = ovf_r;
    assign done        = done_r;
    assign halt_pulse  = halt_pulse_r;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a behavioural model pushes expected outputs
// per clock edge, and each scenario task pops and compares them against the DUT.
module tb_perf_counter_unit;

    typedef struct packed {
        logic [31:0] cycles;
        logic [31:0] instret;
        logic [31:0] branches;
        logic [31:0] mispredicts;
        logic [3:0]  ovf;
        logic        done;
        logic        halt_pulse;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_valid = 1'b0;
    logic        retire = 1'b0;
    logic        branch_resolved = 1'b0;
    logic        branch_mispredict = 1'b0;
    logic        clear = 1'b0;
    logic        idle_valid = 1'b0;

    logic [31:0] cycles, instret, branches, mispredicts;
    logic [3:0]  ovf;
    logic        done, halt_pulse;

    logic [3:0]  w_cycles, w_instret, w_branches, w_mispredicts, w_ovf;
    logic        w_done, w_halt_pulse;
    logic [3:0]  s_cycles, s_instret, s_branches, s_mispredicts, s_ovf;
    logic        s_done, s_halt_pulse;

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t sb[$];
    snap_t m;
    bit    m_halted;
    snap_t got;
    snap_t exp_s;

    perf_counter_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .retire(retire),
        .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict), .clear(clear),
        .cycles(cycles), .instret(instret), .branches(branches), .mispredicts(mispredicts),
        .ovf(ovf), .done(done), .halt_pulse(halt_pulse)
    );

    perf_counter_unit #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(idle_valid), .retire(retire),
        .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict), .clear(clear),
        .cycles(w_cycles), .instret(w_instret), .branches(w_branches), .mispredicts(w_mispredicts),
        .ovf(w_ovf), .done(w_done), .halt_pulse(w_halt_pulse)
    );

    perf_counter_unit #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(idle_valid), .retire(retire),
        .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict), .clear(clear),
        .cycles(s_cycles), .instret(s_instret), .branches(s_branches), .mispredicts(s_mispredicts),
        .ovf(s_ovf), .done(s_done), .halt_pulse(s_halt_pulse)
    );

    always #5 clk = ~clk;

    function automatic snap_t dut_snap();
        snap_t s;
        s = '{cycles, instret, branches, mispredicts, ovf, done, halt_pulse};
        return s;
    endfunction

    task automatic model_reset();
        m        = '0;
        m_halted = 1'b0;
        sb.delete();
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, queue the expectation.
    task automatic tick();
        @(posedge clk);
        if (clear) begin
            m        = '0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m.cycles == 32'hFFFF_FFFF) m.ovf[0] = 1'b1;
            m.cycles = m.cycles + 32'd1;
            if (retire) m.instret = m.instret + 32'd1;
            if (branch_resolved) m.branches = m.branches + 32'd1;
            if (branch_resolved && branch_mispredict) m.mispredicts = m.mispredicts + 32'd1;
            if (pc_valid && pc == 32'h44) begin
                m_halted     = 1'b1;
                m.done       = 1'b1;
                m.halt_pulse = 1'b1;
            end else begin
                m.halt_pulse = 1'b0;
            end
        end else begin
            m.halt_pulse = 1'b0;
        end
        sb.push_back(m);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_snap() !== '0 || w_cycles !== 4'd0 || s_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got cyc=%0d ins=%0d br=%0d mp=%0d ovf=%b done=%b hp=%b, expected all zero",
                     cycles, instret, branches, mispredicts, ovf, done, halt_pulse);
        end
    endtask

    task automatic test_halt();
        @(negedge clk);
        pc       = 32'h34;
        pc_valid = 1'b1;
        reset    = 1'b0;
        model_reset();
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp_s = sb.pop_front();
            got   = dut_snap();
            n_checks++;
            if (got !== exp_s) begin
                n_fail++;
                $display("FAIL halt_sb edge%0d: got cyc=%0d done=%b hp=%b, expected cyc=%0d done=%b hp=%b",
                         k, got.cycles, got.done, got.halt_pulse, exp_s.cycles, exp_s.done, exp_s.halt_pulse);
            end
            n_checks++;
            if (k >= 5 && (cycles !== 32'd5 || done !== 1'b1 || halt_pulse !== (k == 5))) begin
                n_fail++;
                $display("FAIL halt_frozen edge%0d: got cyc=%0d done=%b hp=%b, expected cyc=5 done=1 hp=%b",
                         k, cycles, done, halt_pulse, (k == 5));
            end
            if (k < 5) pc = pc + 32'd4;
            else begin
                pc     = (k % 3 == 0) ? 32'h44 : 32'h100;
                retire = 1'b1;
                branch_resolved = 1'b1;
            end
        end
        retire          = 1'b0;
        branch_resolved = 1'b0;
        pc_valid        = 1'b0;
    endtask

    task automatic test_events();
        logic [9:0] ret_pat, br_pat, mp_pat;
        ret_pat = 10'b1101101101;
        br_pat  = 10'b0100100101;
        mp_pat  = 10'b0100000110;
        clear = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            tick();
            clear             = 1'b0;
            exp_s             = sb.pop_front();
            got               = dut_snap();
            n_checks++;
            if (got !== exp_s) begin
                n_fail++;
                $display("FAIL events_sb step%0d: got cyc=%0d ins=%0d br=%0d mp=%0d done=%b, expected cyc=%0d ins=%0d br=%0d mp=%0d done=%b",
                         i, got.cycles, got.instret, got.branches, got.mispredicts, got.done,
                         exp_s.cycles, exp_s.instret, exp_s.branches, exp_s.mispredicts, exp_s.done);
            end
            if (i < 10) begin
                retire            = ret_pat[i];
                branch_resolved   = br_pat[i];
                branch_mispredict = mp_pat[i];
            end else begin
                retire = 1'b0; branch_resolved = 1'b0; branch_mispredict = 1'b0;
                pc = 32'h44; pc_valid = 1'b1;
            end
        end
        n_checks++;
        if (instret !== 32'd7 || branches !== 32'd4 || mispredicts !== 32'd2 || cycles !== 32'd11 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL events_totals: got ins=%0d br=%0d mp=%0d cyc=%0d done=%b, expected ins=7 br=4 mp=2 cyc=11 done=1",
                     instret, branches, mispredicts, cycles, done);
        end
        pc_valid = 1'b0;
    endtask

    task automatic test_invalid_pc();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pc    = 32'h44;
        exp_s = sb.pop_front();
        n_checks++;
        if (dut_snap() !== exp_s) begin
            n_fail++;
            $display("FAIL invpc_clear: got cyc=%0d done=%b, expected cyc=%0d done=%b", cycles, done, exp_s.cycles, exp_s.done);
        end
        for (int k = 1; k <= 4; k++) begin
            pc_valid = (k == 4);
            tick();
            exp_s = sb.pop_front();
            got   = dut_snap();
            n_checks++;
            if (got !== exp_s || done !== (k == 4) || cycles !== k) begin
                n_fail++;
                $display("FAIL invpc_step%0d: got cyc=%0d done=%b hp=%b, expected cyc=%0d done=%b hp=%b",
                         k, got.cycles, got.done, got.halt_pulse, k, (k == 4), (k == 4));
            end
        end
        pc_valid = 1'b0;
    endtask

    task automatic test_clear_halted();
        clear = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_s = sb.pop_front();
            got   = dut_snap();
            n_checks++;
            if (got !== exp_s || cycles !== ((k % 2 == 0) ? 32'd0 : 32'd1) || done !== 1'b0 || ovf !== 4'b0000) begin
                n_fail++;
                $display("FAIL clear_step%0d: got cyc=%0d done=%b ovf=%b hp=%b, expected cyc=%0d done=0 ovf=0000 hp=0",
                         k, cycles, done, ovf, halt_pulse, (k % 2 == 0) ? 0 : 1);
            end
            clear    = (k == 1);
            pc       = 32'h44;
            pc_valid = (k == 1);
        end
        pc_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_async_reset();
        retire = 1'b1;
        repeat (3) begin
            tick();
            exp_s = sb.pop_front();
            n_checks++;
            if (dut_snap() !== exp_s) begin
                n_fail++;
                $display("FAIL areset_pre: got cyc=%0d ins=%0d, expected cyc=%0d ins=%0d", cycles, instret, exp_s.cycles, exp_s.instret);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_snap() !== '0 || w_cycles !== 4'd0 || s_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_async: got cyc=%0d ins=%0d done=%b small=%0d/%0d, expected all zero",
                     cycles, instret, done, w_cycles, s_cycles);
        end
        model_reset();
        #2 reset = 1'b0;
        tick();
        exp_s = sb.pop_front();
        n_checks++;
        if (dut_snap() !== exp_s || cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL areset_resume: got cyc=%0d ins=%0d, expected cyc=1 ins=1", cycles, instret);
        end
        retire = 1'b0;
    endtask

    task automatic test_overflow();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        model_reset();
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_s = sb.pop_front();
            n_checks++;
            if (dut_snap() !== exp_s) begin
                n_fail++;
                $display("FAIL ovf_main edge%0d: got cyc=%0d, expected cyc=%0d", k, cycles, exp_s.cycles);
            end
            if (k == 15) begin
                n_checks++;
                if (w_cycles !== 4'd15 || w_ovf !== 4'b0000 || s_cycles !== 4'd15 || s_ovf !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL ovf_edge15: got wrap=%0d/%b sat=%0d/%b, expected 15/0000 15/0000", w_cycles, w_ovf, s_cycles, s_ovf);
                end
            end
        end
        n_checks++;
        if (w_cycles !== 4'd1 || w_ovf !== 4'b0001) begin
            n_fail++;
            $display("FAIL ovf_wrap: got cyc=%0d ovf=%b, expected cyc=1 ovf=0001", w_cycles, w_ovf);
        end
        n_checks++;
        if (s_cycles !== 4'd15 || s_ovf !== 4'b0001) begin
            n_fail++;
            $display("FAIL ovf_saturate: got cyc=%0d ovf=%b, expected cyc=15 ovf=0001", s_cycles, s_ovf);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_halt();
        test_events();
        test_invalid_pc();
        test_clear_halted();
        test_async_reset();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
